// File: rtl/bus_pkg.sv
// Shared types and helpers for the CPU-to-APB bridge.
// Holds the access-type enum ({we, funct3}), the FSM state enum, the slave page
// map, the registered APB command payload, and the decode/legality/lane helpers.
package bus_pkg;

  localparam int unsigned NUM_SLAVES = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned DEC_W      = 20;

  // {we, funct3}: loads and stores share funct3 codes, so the write bit keeps the names distinct
  typedef enum logic [3:0] {
    LB  = 4'b0000,
    LH  = 4'b0001,
    LW  = 4'b0010,
    LBU = 4'b0100,
    LHU = 4'b0101,
    SB  = 4'b1000,
    SH  = 4'b1001,
    SW  = 4'b1010
  } access_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Address page (addr[31:12]) of each slave
  localparam logic [NUM_SLAVES-1:0][DEC_W-1:0] SLAVE_BASE = {
    20'h10003, 20'h10002, 20'h10001, 20'h10000
  };

  // Registered APB command driven onto PADDR/PWRITE/PWDATA/PSTRB
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } apb_cmd_t;

  // One-hot slave select from the address page; all-zero when unmapped
  function automatic logic [NUM_SLAVES-1:0] decode(input logic [DEC_W-1:0] page);
    logic [NUM_SLAVES-1:0] sel;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (page == SLAVE_BASE[i]);
    end
    return sel;
  endfunction

  // Mapped, non-reserved and naturally aligned
  function automatic logic req_legal(input logic [2:0] funct3,
                                     input logic [DEC_W-1:0] page,
                                     input logic [1:0] off);
    logic ok;
    ok = |decode(page);
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ok = 1'b0;
    if (funct3[1:0] == 2'b01 && off[0]) ok = 1'b0;
    if (funct3[1:0] == 2'b10 && off != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  // Lane-replicated write data and byte strobes; loads carry no strobes
  function automatic apb_cmd_t build_cmd(input logic we, input logic [2:0] funct3,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] wdata);
    apb_cmd_t cmd;
    cmd.addr  = addr;
    cmd.write = we;
    cmd.wdata = wdata;
    cmd.strb  = '0;
    if (we) begin
      case (funct3[1:0])
        2'b00: begin
          cmd.wdata = {4{wdata[7:0]}};
          cmd.strb  = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          cmd.wdata = {2{wdata[15:0]}};
          cmd.strb  = 4'b0011 << addr[1:0];
        end
        default: begin
          cmd.wdata = wdata;
          cmd.strb  = 4'b1111;
        end
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/bus_apb_bridge_if.sv
// Bus bundle for the bridge: CPU request/response side plus the APB side.
// modport master : the bridge (APB master, CPU-side responder).
// modport slave  : the environment (CPU and the four APB slaves).
interface bus_apb_bridge_if;
  import bus_pkg::*;

  logic                  busReq;
  logic                  busWe;
  logic [ADDR_W-1:0]     busAddr;
  logic [DATA_W-1:0]     busWData;
  logic [2:0]            strb;
  logic [DATA_W-1:0]     busRData;
  logic                  busReady;
  logic                  busErr;

  logic [ADDR_W-1:0]     PADDR;
  logic                  PWRITE;
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic [DATA_W-1:0]     PWDATA;
  logic [STRB_W-1:0]     PSTRB;
  logic [DATA_W-1:0]     PRDATA0;
  logic [DATA_W-1:0]     PRDATA1;
  logic [DATA_W-1:0]     PRDATA2;
  logic [DATA_W-1:0]     PRDATA3;
  logic [NUM_SLAVES-1:0] PREADY;

  modport master (
    input  busReq, busWe, busAddr, busWData, strb,
    output busRData, busReady, busErr,
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );

  modport slave (
    output busReq, busWe, busAddr, busWData, strb,
    input  busRData, busReady, busErr,
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );

endinterface

// File: rtl/bus_load_align.sv
// Combinational load extraction: picks the byte/halfword at byte_off and
// sign- or zero-extends it by funct3; LW passes the word through.
// Ports: funct3 (load size/sign), byte_off (addr[1:0]), rdata (slave word),
//        data_c (extended load result).
module bus_load_align
  import bus_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data_c
);

  logic [15:0] lane;

  always_comb begin
    lane   = 16'(rdata >> {byte_off, 3'b000});
    data_c = rdata;
    case ({1'b0, funct3})
      LB:      data_c = {{24{lane[7]}}, lane[7:0]};
      LBU:     data_c = {24'h000000, lane[7:0]};
      LH:      data_c = {{16{lane[15]}}, lane};
      LHU:     data_c = {16'h0000, lane};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/bus_apb_bridge.sv
// CPU load/store to APB bridge, FSM IDLE -> SETUP -> ACCESS -> DONE.
// Illegal requests (misaligned, reserved funct3, unmapped) skip the APB bus
// and complete with busErr. Optional ACCESS watchdog under APB_TIMEOUT_EN.
// Ports: clk, reset (async active-low), bus (bus_apb_bridge_if.master:
//        CPU busReq/busWe/busAddr/busWData/strb -> busRData/busReady/busErr,
//        APB PADDR/PWRITE/PSEL/PENABLE/PWDATA/PSTRB <- PRDATA0..3/PREADY).
module bus_apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned NUM_SLAVES     = bus_pkg::NUM_SLAVES
) (
  input  logic             clk,
  input  logic             reset,
  bus_apb_bridge_if.master bus
);
  import bus_pkg::*;

  if (NUM_SLAVES != 4 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("bus_apb_bridge: NUM_SLAVES must be 4 and TIMEOUT_CYCLES nonzero");
  end

  state_e                state_q, state_d;
  apb_cmd_t              cmd_q, cmd_d;
  logic [2:0]            f3_q, f3_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [NUM_SLAVES-1:0] dec_c;
  logic                  legal_c;
  logic                  pready_sel_c;
  logic [DATA_W-1:0]     prdata_sel_c;
  logic [DATA_W-1:0]     load_data_c;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Request decode and selected-slave response muxing
  always_comb begin
    dec_c        = decode(bus.busAddr[ADDR_W-1 -: DEC_W]);
    legal_c      = req_legal(bus.strb, bus.busAddr[ADDR_W-1 -: DEC_W], bus.busAddr[1:0]);
    pready_sel_c = |(bus.PREADY & psel_q);
    prdata_sel_c = ({DATA_W{psel_q[0]}} & bus.PRDATA0) |
                   ({DATA_W{psel_q[1]}} & bus.PRDATA1) |
                   ({DATA_W{psel_q[2]}} & bus.PRDATA2) |
                   ({DATA_W{psel_q[3]}} & bus.PRDATA3);
  end

  bus_load_align u_load_align (
    .funct3   (f3_q),
    .byte_off (cmd_q.addr[1:0]),
    .rdata    (prdata_sel_c),
    .data_c   (load_data_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    f3_d      = f3_q;
    psel_d    = '0;
    penable_d = 1'b0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
`ifdef APB_TIMEOUT_EN
    cnt_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.busReq) begin
          if (legal_c) begin
            state_d = SETUP;
            cmd_d   = build_cmd(bus.busWe, bus.strb, bus.busAddr, bus.busWData);
            f3_d    = bus.strb;
            psel_d  = dec_c;
          end else begin
            state_d = DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = psel_q;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready_sel_c) begin
          state_d = DONE;
          ready_d = 1'b1;
          rdata_d = cmd_q.write ? '0 : load_data_c;
        end else begin
          psel_d    = psel_q;
          penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
          // Abort on the TIMEOUT_CYCLES-th consecutive stalled ACCESS cycle
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = DONE;
            psel_d    = '0;
            penable_d = 1'b0;
            ready_d   = 1'b1;
            err_d     = 1'b1;
            rdata_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q     <= '0;
      f3_q      <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cmd_q     <= cmd_d;
      f3_q      <= f3_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // Stall counter for the ACCESS watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.PADDR    = cmd_q.addr;
  assign bus.PWRITE   = cmd_q.write;
  assign bus.PWDATA   = cmd_q.wdata;
  assign bus.PSTRB    = cmd_q.strb;
  assign bus.PSEL     = psel_q;
  assign bus.PENABLE  = penable_q;
  assign bus.busRData = rdata_q;
  assign bus.busReady = ready_q;
  assign bus.busErr   = err_q;

endmodule

// File: tb/tb_bus_apb_bridge.sv
// Directed bench for bus_apb_bridge: expected completions are queued when a
// request is driven and compared when busReady appears.
module tb_bus_apb_bridge;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_apb_bridge_if bif ();

  bus_apb_bridge #(.TIMEOUT_CYCLES(4), .NUM_SLAVES(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check32({tag, "_rdata"}, bif.busRData, 32'h0);
    check32({tag, "_ctl"}, 32'({bif.busReady, bif.busErr, bif.PWRITE, bif.PENABLE, bif.PSEL, bif.PSTRB}), 32'h0);
    check32({tag, "_paddr"}, bif.PADDR, 32'h0);
    check32({tag, "_pwdata"}, bif.PWDATA, 32'h0);
  endtask

  // Starts in an IDLE cycle (#1 after the edge) and returns in the following IDLE cycle
  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int unsigned stall, input bit drop_early,
                      input logic [3:0] e_psel, input logic [31:0] e_pwdata,
                      input logic [3:0] e_pstrb, input logic [31:0] e_rdata,
                      input logic e_err, input int unsigned e_lat);
    exp_t        e;
    int unsigned cyc;
    int unsigned acc;
    bit          done;
    e.rdata = e_rdata;
    e.err   = e_err;
    e.lat   = e_lat;
    sb_q.push_back(e);
    bif.busReq   = 1'b1;
    bif.busWe    = we;
    bif.strb     = f3;
    bif.busAddr  = addr;
    bif.busWData = wdata;
    bif.PREADY   = (stall > 0) ? ~e_psel : 4'hF;
    cyc  = 0;
    acc  = 0;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop_early && cyc == 1) bif.busReq = 1'b0;
      if (cyc == 1) begin
        check32({tag, "_psel_setup"}, 32'(bif.PSEL), 32'(e_psel));
        if (e_psel != 4'h0) begin
          check32({tag, "_penable_setup"}, 32'(bif.PENABLE), 32'h0);
          check32({tag, "_paddr"}, bif.PADDR, addr);
          check32({tag, "_pwrite"}, 32'(bif.PWRITE), 32'(we));
          check32({tag, "_pstrb"}, 32'(bif.PSTRB), 32'(e_pstrb));
          if (we) check32({tag, "_pwdata"}, bif.PWDATA, e_pwdata);
        end
      end
      if (bif.PENABLE) begin
        acc++;
        if (acc == 1) check32({tag, "_psel_access"}, 32'(bif.PSEL), 32'(e_psel));
        if (acc > stall) bif.PREADY = 4'hF;
      end
      if (bif.busReady) begin
        done         = 1'b1;
        bif.busReq   = 1'b0;
        bif.PREADY   = 4'hF;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s_sb: observed busReady expected no pending entry", tag);
        end else begin
          e = sb_q.pop_front();
          check32({tag, "_rdata"}, bif.busRData, e.rdata);
          check32({tag, "_err"}, 32'(bif.busErr), 32'(e.err));
          check32({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_wait: observed no busReady expected busReady within 64 cycles", tag);
      bif.busReq = 1'b0;
      bif.PREADY = 4'hF;
    end
    @(posedge clk);
    #1;
    check32({tag, "_ready_pulse"}, 32'({bif.busReady, bif.PSEL, bif.PENABLE}), 32'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bif.busReq   = 1'b0;
    bif.busWe    = 1'b0;
    bif.busAddr  = '0;
    bif.busWData = '0;
    bif.strb     = '0;
    bif.PRDATA0  = '0;
    bif.PRDATA1  = '0;
    bif.PRDATA2  = '0;
    bif.PRDATA3  = '0;
    bif.PREADY   = 4'hF;
    #12;
    check_outs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs_zero("post_reset");

    xfer("sw_word", 1'b1, 3'b010, 32'h1000_0004, 32'hCAFE_BABE, 0, 1'b0,
         4'b0001, 32'hCAFE_BABE, 4'b1111, 32'h0, 1'b0, 3);

    bif.PRDATA2 = 32'h80FF_0000;
    xfer("lb", 1'b0, 3'b000, 32'h1000_2003, 32'h0, 0, 1'b0,
         4'b0100, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b0, 3);
    xfer("lbu", 1'b0, 3'b100, 32'h1000_2003, 32'h0, 0, 1'b0,
         4'b0100, 32'h0, 4'b0000, 32'h0000_0080, 1'b0, 3);

    xfer("sh_stall", 1'b1, 3'b001, 32'h1000_1002, 32'h0000_1234, 3, 1'b1,
         4'b0010, 32'h1234_1234, 4'b1100, 32'h0, 1'b0, 6);

    bif.PRDATA3 = 32'h8001_7FFF;
    xfer("lh", 1'b0, 3'b001, 32'h1000_3002, 32'h0, 0, 1'b0,
         4'b1000, 32'h0, 4'b0000, 32'hFFFF_8001, 1'b0, 3);
    xfer("lhu", 1'b0, 3'b101, 32'h1000_3000, 32'h0, 1, 1'b0,
         4'b1000, 32'h0, 4'b0000, 32'h0000_7FFF, 1'b0, 4);

    xfer("sb", 1'b1, 3'b000, 32'h1000_0001, 32'h0000_00A5, 0, 1'b0,
         4'b0001, 32'hA5A5_A5A5, 4'b0010, 32'h0, 1'b0, 3);

    bif.PRDATA0 = 32'h1234_5678;
    xfer("lw", 1'b0, 3'b010, 32'h1000_0000, 32'h0, 0, 1'b0,
         4'b0001, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 3);
    repeat (3) @(posedge clk);
    #1;
    check32("rdata_hold", bif.busRData, 32'h1234_5678);

    xfer("lw_misaligned", 1'b0, 3'b010, 32'h1000_0002, 32'h0, 0, 1'b0,
         4'b0000, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
    xfer("lw_unmapped", 1'b0, 3'b010, 32'h2000_0000, 32'h0, 0, 1'b0,
         4'b0000, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
    xfer("rsvd_f3", 1'b0, 3'b011, 32'h1000_0000, 32'h0, 0, 1'b0,
         4'b0000, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
    xfer("sh_misaligned", 1'b1, 3'b001, 32'h1000_1001, 32'h0000_BEEF, 0, 1'b0,
         4'b0000, 32'h0, 4'b0000, 32'h0, 1'b1, 1);

    // Reset asserted mid-ACCESS clears outputs without waiting for an edge
    bif.busReq  = 1'b1;
    bif.busWe   = 1'b1;
    bif.strb    = 3'b010;
    bif.busAddr = 32'h1000_3000;
    bif.busWData = 32'h5555_AAAA;
    bif.PREADY  = 4'b0111;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check32("mid_access_penable", 32'(bif.PENABLE), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs_zero("async_reset");
    bif.busReq = 1'b0;
    bif.PREADY = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs_zero("after_async_reset");

    xfer("sw_after_reset", 1'b1, 3'b010, 32'h1000_1008, 32'hDEAD_BEEF, 0, 1'b0,
         4'b0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 3);

`ifdef APB_TIMEOUT_EN
    xfer("lw_timeout", 1'b0, 3'b010, 32'h1000_3000, 32'h0, 1000, 1'b0,
         4'b1000, 32'h0, 4'b0000, 32'h0, 1'b1, 6);
`endif

    check32("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_apb_bridge.md
BUS_APB_BRIDGE -- requirements
Module: bus_apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of PREADY-low ACCESS cycles before abort (used only with APB_TIMEOUT_EN).
REQ-002 SHALL have parameter NUM_SLAVES, default 4, the number of APB slaves decoded (fixed at 4 in this revision).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- busReq  in  1  CPU access request, held until busReady.
- busWe  in  1  1 = store, 0 = load.
- busAddr  in  32  byte address.
- busWData  in  32  store data, right-aligned.
- strb  in  3  RISC-V funct3 access size and sign.
- busRData  out  32  load result, extended.
- busReady  out  1  one-cycle completion pulse.
- busErr  out  1  error qualifier, valid with busReady.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB write.
- PSEL  out  4  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  lane-replicated write data.
- PSTRB  out  4  byte-lane strobes.
- PRDATA0..PRDATA3  in  32 each  slave read data.
- PREADY  in  4  per-slave ready.

Function
REQ-005 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-006 In IDLE, busReq=1 with a legal request SHALL register the address, data, PWRITE, PSTRB and slave select, then go to SETUP.
REQ-007 In IDLE, busReq=1 with an illegal request SHALL go directly to DONE with busErr=1 and busRData=0, and no PSEL.
- Illegal = misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), reserved funct3 (011, 110, 111), or unmapped address.
REQ-008 Decode SHALL use busAddr[31:12]:
- 0x10000 -> PSEL[0]
- 0x10001 -> PSEL[1]
- 0x10002 -> PSEL[2]
- 0x10003 -> PSEL[3]
- any other value is unmapped.
REQ-009 In SETUP, the selected PSEL bit SHALL be 1 with PENABLE=0, and the FSM SHALL go to ACCESS.
REQ-010 In ACCESS, PENABLE SHALL be 1; the FSM SHALL remain in ACCESS while the selected PREADY is 0 and go to DONE when it is 1.
REQ-011 On the ACCESS-to-DONE transition, PRDATA of the selected slave SHALL be captured.
REQ-012 PADDR, PWRITE, PWDATA and PSTRB SHALL be stable from SETUP through the last ACCESS cycle; PSEL and PENABLE SHALL be 0 in IDLE and DONE.
REQ-013 Store lanes SHALL be:
- SB: PWDATA={4{wdata[7:0]}}, PSTRB=0001<<addr[1:0]
- SH: PWDATA={2{wdata[15:0]}}, PSTRB=0011<<addr[1:0]
- SW: PWDATA=wdata, PSTRB=1111
- loads: PSTRB=0000.
REQ-014 Loads SHALL select the byte or halfword at addr[1:0] and sign-extend it (LB, LH) or zero-extend it (LBU, LHU); LW SHALL pass the word through unchanged.
REQ-015 In DONE, busReady SHALL be 1 for exactly one cycle with busRData and busErr valid; busRData SHALL be held until the next DONE.
REQ-016 Minimum latency SHALL be 3 cycles for a legal access (request sampled in cycle 0, busReady in cycle 3) and 1 cycle for an illegal access.
REQ-017 busReq still high on return to IDLE SHALL start a new transfer; busReq changes outside IDLE SHALL be ignored.

Reset
REQ-018 With reset=0, the FSM SHALL go to IDLE and every output and internal register SHALL be 0 immediately, including mid-transfer.

Configuration
REQ-019 With APB_TIMEOUT_EN defined, a counter SHALL count consecutive ACCESS cycles with the selected PREADY low.
- On reaching TIMEOUT_CYCLES, the transfer SHALL abort: next state DONE, busErr=1, busRData=0.
REQ-020 With APB_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-021 Package bus_pkg SHALL hold the funct3 enum (LB/LH/LW/LBU/LHU/SB/SH/SW), the FSM state enum, the slave base-address constants and NUM_SLAVES.
REQ-022 Load extraction and extension SHALL be in the combinational sub-module bus_load_align.

Verification
REQ-023 SW 0x1000_0004, wdata 0xCAFEBABE, PREADY=1111 -> PSEL=0001, PSTRB=1111, PWDATA=0xCAFEBABE; busReady in cycle 3, busErr=0.
REQ-024 LB 0x1000_2003 with PRDATA2=0x80FF0000 -> busRData=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-025 SH 0x1000_1002, wdata 0x00001234, PREADY[1] low for 3 ACCESS cycles -> PWDATA=0x12341234, PSTRB=1100; busReady in cycle 6.
REQ-026 LW 0x1000_0002, and separately LW 0x2000_0000 -> PSEL stays 0000; busReady and busErr=1 in cycle 1; busRData=0.
REQ-027 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY[3] held 0 -> abort after 4 ACCESS cycles with busErr=1; reset pulled low in ACCESS -> all outputs 0 in the same cycle.
